// File: rtl/ps2_id_entry.sv
// ----------------------------------------------------------------------------
// ps2_id_entry
//
// Turns raw PS/2 scancode bytes into an N-digit BCD ID for the parking
// controller. The block parses E0/F0 prefixes, tracks whether a Ctrl key is
// down, and handles digit entry, backspace, Esc-clear, Enter-commit and an
// inactivity timeout that discards a partial entry.
//
// Parameters
//   N_DIGITS  digits per ID (1..15)
//   BLANK     nibble value that marks an empty digit position
//   TIMEOUT   idle clk cycles before a partial entry is dropped (0 = never)
//
// Ports
//   clk, reset      rising-edge clock; asynchronous active-high reset
//   code_valid      one-cycle strobe: code holds a received byte
//   code            scancode byte (make, E0, F0 or data)
//   entry           digits being typed, newest in [3:0], unused = BLANK
//   digit_count     number of digits currently held
//   entry_full      digit_count == N_DIGITS
//   id_value        last committed ID, held until the next commit
//   id_commit       pulse: id_value was just updated
//   id_reject       pulse: Enter pressed while the entry was not full
//   key_pulse       pulse: a digit was accepted
//   key_val         last accepted digit, BLANK after reset or any clear
//   esc_pulse       pulse: Esc make code
//   ctrla_pulse     pulse: A make code while Ctrl is held
//   ctrl_held       left or right Ctrl currently down
// ----------------------------------------------------------------------------
module ps2_id_entry #(
    parameter int         N_DIGITS = 7,
    parameter logic [3:0] BLANK    = 4'hA,
    parameter int         TIMEOUT  = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  code_valid,
    input  logic [7:0]            code,
    output logic [4*N_DIGITS-1:0] entry,
    output logic [3:0]            digit_count,
    output logic                  entry_full,
    output logic [4*N_DIGITS-1:0] id_value,
    output logic                  id_commit,
    output logic                  id_reject,
    output logic                  key_pulse,
    output logic [3:0]            key_val,
    output logic                  esc_pulse,
    output logic                  ctrla_pulse,
    output logic                  ctrl_held
);

    localparam int W  = 4 * N_DIGITS;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0] T_LAST    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [3:0]    N_MAX     = 4'(N_DIGITS);
    localparam logic [W-1:0]  ALL_BLANK = {N_DIGITS{BLANK}};
    // Backspace shifts right and refills the oldest position with BLANK.
    localparam logic [W-1:0]  TOP_BLANK = W'(BLANK) << (W - 4);

    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_BRK   = 8'hF0;
    localparam logic [7:0] K_CTRL  = 8'h14;
    localparam logic [7:0] K_A     = 8'h1C;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_ESC   = 8'h76;
    localparam logic [7:0] K_BKSP  = 8'h66;

    typedef enum logic [1:0] {
        P_IDLE,
        P_EXT,
        P_BRK,
        P_EXT_BRK
    } parse_t;

    // Top-row and keypad digit make codes; returns {valid, digit}.
    function automatic logic [4:0] digit_of(input logic [7:0] c);
        case (c)
            8'h45, 8'h70: return {1'b1, 4'd0};
            8'h16, 8'h69: return {1'b1, 4'd1};
            8'h1E, 8'h72: return {1'b1, 4'd2};
            8'h26, 8'h7A: return {1'b1, 4'd3};
            8'h25, 8'h6B: return {1'b1, 4'd4};
            8'h2E, 8'h73: return {1'b1, 4'd5};
            8'h36, 8'h74: return {1'b1, 4'd6};
            8'h3D, 8'h6C: return {1'b1, 4'd7};
            8'h3E, 8'h75: return {1'b1, 4'd8};
            8'h46, 8'h7D: return {1'b1, 4'd9};
            default:      return 5'b0;
        endcase
    endfunction

    parse_t          state_q, state_d;
    logic            is_make, is_break, ext;
    logic [4:0]      dig;

    logic [W-1:0]    entry_d, id_d;
    logic [3:0]      count_d, key_val_d;
    logic            commit_d, reject_d, key_d, esc_d, ctrla_d;
    logic            ctrl_l, ctrl_r, ctrl_l_d, ctrl_r_d;
    logic [TW-1:0]   timer_q, timer_d;

    assign entry_full = (digit_count == N_MAX);
    assign ctrl_held  = ctrl_l | ctrl_r;
    assign dig        = digit_of(code);

    // Prefix parser: classifies each strobed byte as prefix, make or break.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        ext      = 1'b0;
        if (code_valid) begin
            unique case (state_q)
                P_IDLE: begin
                    if (code == K_EXT)      state_d = P_EXT;
                    else if (code == K_BRK) state_d = P_BRK;
                    else                    is_make = 1'b1;
                end
                P_EXT: begin
                    ext = 1'b1;
                    if (code == K_EXT)      state_d = P_EXT;
                    else if (code == K_BRK) state_d = P_EXT_BRK;
                    else begin
                        is_make = 1'b1;
                        state_d = P_IDLE;
                    end
                end
                P_BRK: begin
                    if (code != K_BRK) begin
                        is_break = 1'b1;
                        state_d  = P_IDLE;
                    end
                end
                P_EXT_BRK: begin
                    ext      = 1'b1;
                    is_break = 1'b1;
                    state_d  = P_IDLE;
                end
                default: state_d = P_IDLE;
            endcase
        end
    end

    // Key actions and inactivity timer.
    always_comb begin
        entry_d   = entry;
        count_d   = digit_count;
        id_d      = id_value;
        key_val_d = key_val;
        ctrl_l_d  = ctrl_l;
        ctrl_r_d  = ctrl_r;
        timer_d   = timer_q;
        commit_d  = 1'b0;
        reject_d  = 1'b0;
        key_d     = 1'b0;
        esc_d     = 1'b0;
        ctrla_d   = 1'b0;

        if (is_make) begin
            if (code == K_CTRL) begin
                if (ext) ctrl_r_d = 1'b1;
                else     ctrl_l_d = 1'b1;
            end else if (code == K_A) begin
                ctrla_d = ctrl_held;
            end else if (code == K_ENTER) begin
                if (entry_full) begin
                    id_d      = entry;
                    commit_d  = 1'b1;
                    entry_d   = ALL_BLANK;
                    count_d   = 4'd0;
                    key_val_d = BLANK;
                end else begin
                    reject_d = 1'b1;
                end
            end else if (code == K_ESC) begin
                esc_d     = 1'b1;
                entry_d   = ALL_BLANK;
                count_d   = 4'd0;
                key_val_d = BLANK;
            end else if (!ext && code == K_BKSP) begin
                if (digit_count != 4'd0) begin
                    entry_d = (entry >> 4) | TOP_BLANK;
                    count_d = digit_count - 4'd1;
                end
            end else if (!ext && dig[4] && !ctrl_held && !entry_full) begin
                // Extended keypad codes are navigation keys and never land here.
                entry_d   = (entry << 4) | W'(dig[3:0]);
                count_d   = digit_count + 4'd1;
                key_val_d = dig[3:0];
                key_d     = 1'b1;
            end
        end else if (is_break && code == K_CTRL) begin
            if (ext) ctrl_r_d = 1'b0;
            else     ctrl_l_d = 1'b0;
        end

        // Any received byte restarts the idle timer, so a code arriving on
        // the expiry cycle wins over the timeout.
        if (code_valid) begin
            timer_d = '0;
        end else if (TIMEOUT == 0 || digit_count == 4'd0) begin
            timer_d = '0;
        end else if (timer_q == T_LAST) begin
            entry_d   = ALL_BLANK;
            count_d   = 4'd0;
            key_val_d = BLANK;
            timer_d   = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= P_IDLE;
            entry       <= ALL_BLANK;
            digit_count <= 4'd0;
            id_value    <= ALL_BLANK;
            key_val     <= BLANK;
            ctrl_l      <= 1'b0;
            ctrl_r      <= 1'b0;
            timer_q     <= '0;
            id_commit   <= 1'b0;
            id_reject   <= 1'b0;
            key_pulse   <= 1'b0;
            esc_pulse   <= 1'b0;
            ctrla_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry       <= entry_d;
            digit_count <= count_d;
            id_value    <= id_d;
            key_val     <= key_val_d;
            ctrl_l      <= ctrl_l_d;
            ctrl_r      <= ctrl_r_d;
            timer_q     <= timer_d;
            id_commit   <= commit_d;
            id_reject   <= reject_d;
            key_pulse   <= key_d;
            esc_pulse   <= esc_d;
            ctrla_pulse <= ctrla_d;
        end
    end

endmodule

// File: tb/tb_ps2_id_entry.sv
// ----------------------------------------------------------------------------
// tb_ps2_id_entry
//
// Directed bench for ps2_id_entry (7 digits, BLANK = A, TIMEOUT = 100).
// A table of {byte, expected outputs} records covers digit entry, commit,
// reject, backspace, break/extended filtering, Ctrl tracking and Esc; hand
// sequences cover timeout expiry, code-vs-timeout collision and reset after
// a prefix byte.
// ----------------------------------------------------------------------------
module tb_ps2_id_entry;

    localparam logic [27:0] B7 = 28'hAAAAAAA;

    localparam logic [4:0] P_NONE   = 5'b00000;
    localparam logic [4:0] P_COMMIT = 5'b10000;
    localparam logic [4:0] P_REJECT = 5'b01000;
    localparam logic [4:0] P_KEY    = 5'b00100;
    localparam logic [4:0] P_ESC    = 5'b00010;
    localparam logic [4:0] P_CTRLA  = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [7:0]  code;
    logic [27:0] entry;
    logic [3:0]  digit_count;
    logic        entry_full;
    logic [27:0] id_value;
    logic        id_commit;
    logic        id_reject;
    logic        key_pulse;
    logic [3:0]  key_val;
    logic        esc_pulse;
    logic        ctrla_pulse;
    logic        ctrl_held;

    int total = 0;
    int bad   = 0;

    ps2_id_entry #(
        .N_DIGITS(7),
        .BLANK   (4'hA),
        .TIMEOUT (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code       (code),
        .entry      (entry),
        .digit_count(digit_count),
        .entry_full (entry_full),
        .id_value   (id_value),
        .id_commit  (id_commit),
        .id_reject  (id_reject),
        .key_pulse  (key_pulse),
        .key_val    (key_val),
        .esc_pulse  (esc_pulse),
        .ctrla_pulse(ctrla_pulse),
        .ctrl_held  (ctrl_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [27:0] entry;
        logic [3:0]  count;
        logic [27:0] id;
        logic [4:0]  pulses;
        logic        ctrl;
        logic [3:0]  kv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] c, input logic [27:0] e,
                                input logic [3:0] n, input logic [27:0] id,
                                input logic [4:0] p, input logic ct,
                                input logic [3:0] kv);
        vec_t v;
        v.code = c; v.entry = e; v.count = n; v.id = id;
        v.pulses = p; v.ctrl = ct; v.kv = kv;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [27:0] e,
                                 input logic [3:0] n, input logic [27:0] id,
                                 input logic [4:0] p, input logic ct,
                                 input logic [3:0] kv);
        check({tag, " entry"},  64'(entry), 64'(e));
        check({tag, " count"},  64'(digit_count), 64'(n));
        check({tag, " full"},   64'(entry_full), 64'(n == 4'd7));
        check({tag, " id"},     64'(id_value), 64'(id));
        check({tag, " pulses"},
              64'({id_commit, id_reject, key_pulse, esc_pulse, ctrla_pulse}),
              64'(p));
        check({tag, " ctrl"},   64'(ctrl_held), 64'(ct));
        check({tag, " keyval"}, 64'(key_val), 64'(kv));
    endtask

    // Caller is at a falling edge; the byte is sampled on the next rising
    // edge and the task returns at the falling edge after it.
    task automatic send(input logic [7:0] c);
        code       = c;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // digit entry up to full, overflow ignored
        vecs.push_back(mk(8'h16, 28'hAAAAAA1, 1, B7, P_KEY,  0, 4'h1));
        vecs.push_back(mk(8'h1E, 28'hAAAAA12, 2, B7, P_KEY,  0, 4'h2));
        vecs.push_back(mk(8'h26, 28'hAAAA123, 3, B7, P_KEY,  0, 4'h3));
        vecs.push_back(mk(8'h25, 28'hAAA1234, 4, B7, P_KEY,  0, 4'h4));
        vecs.push_back(mk(8'h2E, 28'hAA12345, 5, B7, P_KEY,  0, 4'h5));
        vecs.push_back(mk(8'h36, 28'hA123456, 6, B7, P_KEY,  0, 4'h6));
        vecs.push_back(mk(8'h3D, 28'h1234567, 7, B7, P_KEY,  0, 4'h7));
        vecs.push_back(mk(8'h3E, 28'h1234567, 7, B7, P_NONE, 0, 4'h7));
        // commit, then reject on empty entry
        vecs.push_back(mk(8'h5A, B7, 0, 28'h1234567, P_COMMIT, 0, 4'hA));
        vecs.push_back(mk(8'h5A, B7, 0, 28'h1234567, P_REJECT, 0, 4'hA));
        // keypad digits and backspace
        vecs.push_back(mk(8'h69, 28'hAAAAAA1, 1, 28'h1234567, P_KEY,  0, 4'h1));
        vecs.push_back(mk(8'h72, 28'hAAAAA12, 2, 28'h1234567, P_KEY,  0, 4'h2));
        vecs.push_back(mk(8'h66, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 0, 4'h2));
        // break stream and extended keypad code ignored
        vecs.push_back(mk(8'hF0, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 0, 4'h2));
        vecs.push_back(mk(8'h69, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 0, 4'h2));
        vecs.push_back(mk(8'hE0, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 0, 4'h2));
        vecs.push_back(mk(8'h69, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 0, 4'h2));
        // left Ctrl, Ctrl+A, digit blocked while Ctrl held, release
        vecs.push_back(mk(8'h14, 28'hAAAAAA1, 1, 28'h1234567, P_NONE,  1, 4'h2));
        vecs.push_back(mk(8'h1C, 28'hAAAAAA1, 1, 28'h1234567, P_CTRLA, 1, 4'h2));
        vecs.push_back(mk(8'h16, 28'hAAAAAA1, 1, 28'h1234567, P_NONE,  1, 4'h2));
        vecs.push_back(mk(8'hF0, 28'hAAAAAA1, 1, 28'h1234567, P_NONE,  1, 4'h2));
        vecs.push_back(mk(8'h14, 28'hAAAAAA1, 1, 28'h1234567, P_NONE,  0, 4'h2));
        // right Ctrl press / release
        vecs.push_back(mk(8'hE0, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 0, 4'h2));
        vecs.push_back(mk(8'h14, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 1, 4'h2));
        vecs.push_back(mk(8'hE0, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 1, 4'h2));
        vecs.push_back(mk(8'hF0, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 1, 4'h2));
        vecs.push_back(mk(8'h14, 28'hAAAAAA1, 1, 28'h1234567, P_NONE, 0, 4'h2));
        // Esc clears
        vecs.push_back(mk(8'h76, B7, 0, 28'h1234567, P_ESC, 0, 4'hA));
        // duplicate E0 prefix still gives right Ctrl
        vecs.push_back(mk(8'hE0, B7, 0, 28'h1234567, P_NONE, 0, 4'hA));
        vecs.push_back(mk(8'hE0, B7, 0, 28'h1234567, P_NONE, 0, 4'hA));
        vecs.push_back(mk(8'h14, B7, 0, 28'h1234567, P_NONE, 1, 4'hA));
        vecs.push_back(mk(8'hE0, B7, 0, 28'h1234567, P_NONE, 1, 4'hA));
        vecs.push_back(mk(8'hF0, B7, 0, 28'h1234567, P_NONE, 1, 4'hA));
        vecs.push_back(mk(8'h14, B7, 0, 28'h1234567, P_NONE, 0, 4'hA));
        // duplicate F0 prefix: following digit is a break, not a make
        vecs.push_back(mk(8'hF0, B7, 0, 28'h1234567, P_NONE, 0, 4'hA));
        vecs.push_back(mk(8'hF0, B7, 0, 28'h1234567, P_NONE, 0, 4'hA));
        vecs.push_back(mk(8'h16, B7, 0, 28'h1234567, P_NONE, 0, 4'hA));
        vecs.push_back(mk(8'h16, 28'hAAAAAA1, 1, 28'h1234567, P_KEY, 0, 4'h1));
        vecs.push_back(mk(8'h76, B7, 0, 28'h1234567, P_ESC,  0, 4'hA));
        // backspace on empty entry, extended Enter rejects
        vecs.push_back(mk(8'h66, B7, 0, 28'h1234567, P_NONE,   0, 4'hA));
        vecs.push_back(mk(8'hE0, B7, 0, 28'h1234567, P_NONE,   0, 4'hA));
        vecs.push_back(mk(8'h5A, B7, 0, 28'h1234567, P_REJECT, 0, 4'hA));

        reset      = 1'b1;
        code_valid = 1'b0;
        code       = 8'h00;
        repeat (2) @(negedge clk);
        check_outputs("reset", B7, 0, B7, P_NONE, 0, 4'hA);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].code);
            check_outputs($sformatf("v%0d(%02h)", i, vecs[i].code), vecs[i].entry,
                          vecs[i].count, vecs[i].id, vecs[i].pulses,
                          vecs[i].ctrl, vecs[i].kv);
        end

        // Timeout: 99 idle cycles keep the entry, the 100th clears it.
        send(8'h16);
        send(8'h1E);
        send(8'h26);
        repeat (99) @(negedge clk);
        check("to99 entry", 64'(entry), 64'(28'hAAAA123));
        check("to99 count", 64'(digit_count), 64'd3);
        @(negedge clk);
        check("to100 entry", 64'(entry), 64'(B7));
        check("to100 count", 64'(digit_count), 64'd0);
        check("to100 pulses",
              64'({id_commit, id_reject, key_pulse, esc_pulse, ctrla_pulse}), 64'd0);

        // Code arriving on the expiry cycle wins and restarts the timer.
        send(8'h16);
        repeat (99) @(negedge clk);
        send(8'h1E);
        check("coll entry", 64'(entry), 64'(28'hAAAAA12));
        check("coll count", 64'(digit_count), 64'd2);
        check("coll key",   64'(key_pulse), 64'd1);
        repeat (99) @(negedge clk);
        check("restart99 count", 64'(digit_count), 64'd2);
        @(negedge clk);
        check("restart100 entry", 64'(entry), 64'(B7));

        // Esc mid-entry
        send(8'h3D);
        send(8'h76);
        check_outputs("esc mid", B7, 0, 28'h1234567, P_ESC, 0, 4'hA);

        // Reset right after E0: parser back to IDLE, next 16 is digit 1.
        send(8'h16);
        send(8'hE0);
        reset = 1'b1;
        #1;
        check_outputs("rst-after-E0", B7, 0, B7, P_NONE, 0, 4'hA);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'h16);
        check_outputs("post-rst 16", 28'hAAAAAA1, 1, B7, P_KEY, 0, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
